// File: rtl/irq_arbiter.sv
// irq_arbiter: interrupt arbiter/sequencer for the 5-stage MIPS pipeline.
//   Per-source edge detection feeds a pending register. The lowest-index
//   pending and unmasked source is requested on the decoder IRQ input, but
//   only when it is safe to do so. The request is then held until the core
//   acknowledges it, and the service window is tracked until eret.
// Ports:
//   clk, reset (async, active low)
//   src_irq[NSRC]   raw level requests; each 0->1 edge is an event
//   pc31, ctl_flow, stall   ID-stage safety qualifiers
//   irq_ack, eret   core handshake
//   irq, in_service status toward the core
//   mem_addr/mem_wdata/mem_we/mem_re/rdata   MEM-stage register bus
//     (IMASK @BASE, IPEND @BASE+4, ICAUSE @BASE+8)

// One source lane: edge detector plus pending bit.
module irq_arbiter_lane (
  input  logic clk,
  input  logic reset,
  input  logic primed,   // low on the first cycle after reset
  input  logic srcIrq,
  input  logic clr,      // W1C or ack clear
  output logic pend
);
  logic srcQ;
  logic ev;

  // Suppress events until srcQ has sampled the line once after reset.
  // Otherwise a line that is already high when reset is released would look
  // like a new edge.
  assign ev = primed & srcIrq & ~srcQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      srcQ <= 1'b0;
      pend <= 1'b0;
    end else begin
      srcQ <= srcIrq;
      if (ev)       pend <= 1'b1;   // a new event beats any clear
      else if (clr) pend <= 1'b0;
    end
  end
endmodule

module irq_arbiter #(
  parameter int          NSRC = 4,
  parameter logic [31:0] BASE = 32'h4000_0030
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic            pc31,
  input  logic            ctl_flow,
  input  logic            stall,
  input  logic            irq_ack,
  input  logic            eret,
  output logic            irq,
  output logic            in_service,
  input  logic [31:0]     mem_addr,
  input  logic [31:0]     mem_wdata,
  input  logic            mem_we,
  input  logic            mem_re,
  output logic [31:0]     rdata
);
  typedef enum logic [1:0] {IDLE, REQ, SERVE} state_t;

  state_t          state, nextState;
  logic [NSRC-1:0] imask, ipend, eligible, w1c, ackClr;
  logic            causeVld;
  logic [2:0]      causeIdx, winner;
  logic            primed;
  logic            hitMask, hitPend, hitCause, takeIrq;
  logic            unusedBits;

  assign unusedBits = ^{mem_addr[1:0], mem_wdata};

  assign hitMask  = mem_addr[31:2] == BASE[31:2];
  assign hitPend  = mem_addr[31:2] == BASE[31:2] + 30'd1;
  assign hitCause = mem_addr[31:2] == BASE[31:2] + 30'd2;

  assign eligible = ipend & imask;
  assign w1c      = (mem_we && hitPend) ? mem_wdata[NSRC-1:0] : '0;

  // Lowest set index wins.
  always_comb begin
    winner = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (eligible[i]) winner = 3'(i);
  end

  always_comb begin
    for (int i = 0; i < NSRC; i++)
      ackClr[i] = (state == REQ) && irq_ack && (causeIdx == 3'(i));
  end

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : gLane
      irq_arbiter_lane uLane (
        .clk    (clk),
        .reset  (reset),
        .primed (primed),
        .srcIrq (src_irq[g]),
        .clr    (w1c[g] | ackClr[g]),
        .pend   (ipend[g])
      );
    end
  endgenerate

  // A branch or jump in ID would corrupt the saved PC, so delivery also
  // waits for a non-control-flow, non-kernel, unstalled ID instruction.
  assign takeIrq = (eligible != '0) && !pc31 && !ctl_flow && !stall;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (takeIrq) nextState = REQ;
      REQ:     if (irq_ack) nextState = SERVE;
      SERVE:   if (eret)    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign irq        = state == REQ;
  assign in_service = state == SERVE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      imask    <= '0;
      causeVld <= 1'b0;
      causeIdx <= 3'd0;
      primed   <= 1'b0;
    end else begin
      state  <= nextState;
      primed <= 1'b1;
      // The IDLE decision this cycle still sees the old mask.
      if (mem_we && hitMask) imask <= mem_wdata[NSRC-1:0];
      if (state == IDLE && takeIrq) begin
        causeVld <= 1'b1;
        causeIdx <= winner;
      end else if (state == SERVE && eret) begin
        causeVld <= 1'b0;   // index is kept for debug
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (mem_re) begin
      if (hitMask)       rdata = 32'(imask);
      else if (hitPend)  rdata = 32'(ipend);
      else if (hitCause) rdata = {causeVld, 28'b0, causeIdx};
    end
  end
endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;
  localparam logic [31:0] AMASK  = 32'h4000_0030;
  localparam logic [31:0] APEND  = 32'h4000_0034;
  localparam logic [31:0] ACAUSE = 32'h4000_0038;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src_irq;
  logic        pc31, ctl_flow, stall, irq_ack, eret;
  logic        irq, in_service;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic        mem_we, mem_re;

  int nChecks = 0;
  int nPass   = 0;
  logic [31:0] d;

  always #5 clk = ~clk;

  irq_arbiter #(.NSRC(4), .BASE(32'h4000_0030)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .pc31(pc31),
    .ctl_flow(ctl_flow), .stall(stall), .irq_ack(irq_ack), .eret(eret),
    .irq(irq), .in_service(in_service), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .rdata(rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    mem_addr = a; mem_re = 1'b1; #1;
    v = rdata; mem_re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    mem_addr = a; mem_wdata = v; mem_we = 1'b1;
    tick();
    mem_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; src_irq = '0; pc31 = 0; ctl_flow = 0; stall = 0;
    irq_ack = 0; eret = 0; mem_addr = '0; mem_wdata = '0; mem_we = 0; mem_re = 0;
    #3;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_insvc", 32'(in_service), 32'd0);
    rd(ACAUSE, d); chk("rst_cause", d, 32'h0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Priority: src 1 and src 2 together, src 1 first.
    wr(AMASK, 32'hF);
    src_irq = 4'b0110; tick(); src_irq = '0;
    chk("pri_noirq_yet", 32'(irq), 32'd0);
    tick();
    chk("pri_irq", 32'(irq), 32'd1);
    rd(ACAUSE, d); chk("pri_cause1", d, 32'h8000_0001);
    irq_ack = 1; tick(); irq_ack = 0;
    rd(APEND, d); chk("pri_pend", d, 32'h4);
    chk("pri_insvc", 32'(in_service), 32'd1);
    chk("pri_irq_low", 32'(irq), 32'd0);
    eret = 1; tick(); eret = 0;
    chk("pri_idle_gap", 32'(irq), 32'd0);
    rd(ACAUSE, d); chk("pri_cause_kept", d, 32'h0000_0001);
    tick();
    chk("pri_irq2", 32'(irq), 32'd1);
    rd(ACAUSE, d); chk("pri_cause2", d, 32'h8000_0002);
    irq_ack = 1; tick(); irq_ack = 0;
    eret = 1; tick(); eret = 0;

    // Safety gating.
    ctl_flow = 1; src_irq = 4'b0001; tick(); src_irq = '0;
    for (int i = 0; i < 3; i++) begin tick(); chk("gate_ctl", 32'(irq), 32'd0); end
    ctl_flow = 0; pc31 = 1;
    for (int i = 0; i < 2; i++) begin tick(); chk("gate_pc31", 32'(irq), 32'd0); end
    pc31 = 0; tick();
    chk("gate_release", 32'(irq), 32'd1);
    rd(ACAUSE, d); chk("gate_cause", d, 32'h8000_0000);
    irq_ack = 1; tick(); irq_ack = 0;
    eret = 1; tick(); eret = 0;

    // Mask and W1C.
    wr(AMASK, 32'h0);
    src_irq = 4'b1000; tick(); src_irq = '0; tick();
    rd(APEND, d); chk("mask_pend", d, 32'h8);
    chk("mask_noirq", 32'(irq), 32'd0);
    src_irq = 4'b1000; wr(APEND, 32'h8); src_irq = '0;
    rd(APEND, d); chk("w1c_vs_set", d, 32'h8);
    wr(APEND, 32'h8);
    rd(APEND, d); chk("w1c_clear", d, 32'h0);
    chk("mask_noirq2", 32'(irq), 32'd0);

    // No withdrawal once requested.
    wr(AMASK, 32'hF);
    src_irq = 4'b1000; tick(); src_irq = '0; tick();
    chk("hold_req", 32'(irq), 32'd1);
    stall = 1; wr(AMASK, 32'h0);
    chk("hold_mask0", 32'(irq), 32'd1);
    tick();
    chk("hold_stall", 32'(irq), 32'd1);
    stall = 0; irq_ack = 1; tick(); irq_ack = 0;
    chk("hold_ack_irq", 32'(irq), 32'd0);
    chk("hold_ack_svc", 32'(in_service), 32'd1);
    rd(ACAUSE, d); chk("hold_cause", d, 32'h8000_0003);
    eret = 1; tick(); eret = 0;
    chk("hold_eret_svc", 32'(in_service), 32'd0);

    // Bus readback.
    wr(AMASK, 32'hFFFF_FFFF);
    rd(AMASK, d); chk("bus_mask", d, 32'h0000_000F);
    mem_addr = AMASK; mem_re = 0; #1;
    chk("bus_nore", rdata, 32'h0);
    wr(ACAUSE, 32'h1234_5678);
    rd(ACAUSE, d); chk("bus_cause_ro", d, 32'h0000_0003);
    rd(AMASK + 32'd12, d); chk("bus_miss", d, 32'h0);

    // Async reset mid-REQ.
    src_irq = 4'b0001; tick(); tick();
    chk("ar_req", 32'(irq), 32'd1);
    #2 reset = 1'b0; #1;
    chk("ar_irq", 32'(irq), 32'd0);
    chk("ar_svc", 32'(in_service), 32'd0);
    rd(AMASK, d);  chk("ar_mask", d, 32'h0);
    rd(APEND, d);  chk("ar_pend", d, 32'h0);
    rd(ACAUSE, d); chk("ar_cause", d, 32'h0);
    tick(); reset = 1'b1;
    tick(); tick();
    rd(APEND, d); chk("ar_level_noev", d, 32'h0);
    src_irq = '0; tick(); src_irq = 4'b0001; tick();
    rd(APEND, d); chk("ar_toggle_ev", d, 32'h1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
